// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Build option: MULDIV_FAST_MULT_EN replaces the iterative multiply with a single-cycle multiplier.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_value,
  input  logic [WIDTH-1:0] rt_value,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic neg, input logic [2*WIDTH-1:0] v);
    return neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d, dbz_out_q, dbz_out_d;

  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               is_mult_q, is_mult_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, dbz_q, dbz_d;

  logic signed [WIDTH-1:0] rs_s, rt_s;
  logic               rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;

  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod, mul_res;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign rs_s   = rs_value;
  assign rt_s   = rt_value;
  assign rs_neg = op[0] & (rs_s < 0);
  assign rt_neg = op[0] & (rt_s < 0);
  assign rs_mag = cond_neg_w(rs_neg, rs_value);
  assign rt_mag = cond_neg_w(rt_neg, rt_value);

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient bits}; restore when the trial goes negative.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  assign prod      = is_mult_q ? fast_prod : acc_q;
`else
  assign prod      = acc_q;
`endif

  // A zero divisor leaves |rs| as remainder, so the dividend-sign fixup returns rs unchanged.
  assign mul_res = cond_neg_2w(neg_lo_q, prod);
  assign fix_hi  = is_mult_q ? mul_res[2*WIDTH-1:WIDTH] : cond_neg_w(neg_hi_q, acc_q[2*WIDTH-1:WIDTH]);
  assign fix_lo  = is_mult_q ? mul_res[WIDTH-1:0]
                             : (dbz_q ? '1 : cond_neg_w(neg_lo_q, acc_q[WIDTH-1:0]));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_out_d = 1'b0;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    is_mult_d = is_mult_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    dbz_d     = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d       = rs_mag;
          b_d       = rt_mag;
          is_mult_d = ~op[1];
          acc_d     = {{WIDTH{1'b0}}, (op[1] ? rs_mag : rt_mag)};
          neg_lo_d  = rs_neg ^ rt_neg;
          neg_hi_d  = op[1] ? rs_neg : (rs_neg ^ rt_neg);
          dbz_d     = op[1] & (rt_value == '0);
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = S_RUN;
`ifdef MULDIV_FAST_MULT_EN
          if (!op[1]) state_d = S_FIX;
`endif
        end else begin
          if (hi_we) hi_d = wr_data;
          if (lo_we) lo_d = wr_data;
        end
      end
      S_RUN: begin
        acc_d = is_mult_q ? mul_next : div_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        hi_d      = fix_hi;
        lo_d      = fix_lo;
        done_d    = 1'b1;
        dbz_out_d = dbz_q;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  // Operand and accumulator registers are only meaningful once loaded by start.
  always_ff @(posedge clk) begin
    a_q       <= a_d;
    b_q       <= b_d;
    acc_q     <= acc_d;
    is_mult_q <= is_mult_d;
    neg_lo_q  <= neg_lo_d;
    neg_hi_q  <= neg_hi_d;
    dbz_q     <= dbz_d;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_out_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: vector table plus random ops through a result scoreboard,
// with hand sequences for busy-time writes, start/MTLO collision and mid-operation reset.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] rs_value, rt_value, wr_data;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .rs_value(rs_value), .rt_value(rt_value),
    .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] rs, rt, hi, lo;
    logic         dbz;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi, lo;
    logic         dbz;
    int           issue;
    int           lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vt[14];
  int   checks = 0, failures = 0, cyc = 0, dones = 0, issued = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [1:0] o);
`ifdef MULDIV_FAST_MULT_EN
    if (!o[1]) return 2;
`endif
    return W + 2;
  endfunction

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        r;
    longint      sa, sbv, q, rm;
    logic [63:0] p;
    r.dbz = 1'b0; r.issue = 0; r.lat = lat_of(o);
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (o)
      2'd0: begin p = {32'b0, a} * {32'b0, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
      2'd1: begin p = 64'(sa * sbv); r.hi = p[63:32]; r.lo = p[31:0]; end
      2'd2: begin
        if (b == '0) begin r.lo = '1; r.hi = a; r.dbz = 1'b1; end
        else begin r.lo = a / b; r.hi = a % b; end
      end
      default: begin
        if (b == '0) begin r.lo = '1; r.hi = a; r.dbz = 1'b1; end
        else begin q = sa / sbv; rm = sa % sbv; r.lo = 32'(q); r.hi = 32'(rm); end
      end
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset_n && done) begin
      dones++;
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        mon_e = sb.pop_front();
        chk("result_hi", 64'(hi), 64'(mon_e.hi));
        chk("result_lo", 64'(lo), 64'(mon_e.lo));
        chk("div_by_zero", 64'(div_by_zero), 64'(mon_e.dbz));
        chk("latency", 64'(cyc - mon_e.issue), 64'(mon_e.lat));
        chk("busy_low_at_done", 64'(busy), 64'(0));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (busy) begin
      checks++; failures++;
      $display("FAIL busy_timeout actual=1 expected=0");
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    wait_idle();
    op = o; rs_value = a; rt_value = b; start = 1'b1;
    e.issue = cyc;
    sb.push_back(e);
    issued++;
    @(negedge clk);
    start = 1'b0;
    rs_value = $urandom; rt_value = $urandom; op = 2'($urandom_range(0, 3));
  endtask

  initial begin
    exp_t e;
    int   n;
    logic [1:0] ro;
    logic [W-1:0] ra, rb;

    vt[0]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vt[1]  = '{2'd1, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vt[2]  = '{2'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vt[3]  = '{2'd2, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
    vt[4]  = '{2'd2, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vt[5]  = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vt[6]  = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vt[7]  = '{2'd0, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000, 1'b0};
    vt[8]  = '{2'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vt[9]  = '{2'd3, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    vt[10] = '{2'd1, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988, 1'b0};
    vt[11] = '{2'd2, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
    vt[12] = '{2'd0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
    vt[13] = '{2'd3, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0};

    start = 1'b0; op = 2'd0; rs_value = '0; rt_value = '0;
    hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_dbz", 64'(div_by_zero), 64'(0));
    chk("reset_hi", 64'(hi), 64'(0));
    chk("reset_lo", 64'(lo), 64'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h13572468;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi_mtlo_hi", 64'(hi), 64'(32'h13572468));
    chk("mthi_mtlo_lo", 64'(lo), 64'(32'h13572468));
    lo_we = 1'b1; wr_data = 32'h0BADF00D;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_only_lo", 64'(lo), 64'(32'h0BADF00D));
    chk("mtlo_only_hi", 64'(hi), 64'(32'h13572468));

    foreach (vt[i]) begin
      e.hi = vt[i].hi; e.lo = vt[i].lo; e.dbz = vt[i].dbz; e.issue = 0; e.lat = lat_of(vt[i].op);
      issue(vt[i].op, vt[i].rs, vt[i].rt, e);
    end

    for (int k = 0; k < 12; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? '0 : $urandom;
      issue(ro, ra, rb, model(ro, ra, rb));
    end

    wait_idle();
    lo_we = 1'b1; wr_data = 32'h00001111;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_idle_1111", 64'(lo), 64'(32'h00001111));
    issue(2'd2, 32'd100, 32'd7, model(2'd2, 32'd100, 32'd7));
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'd1; rs_value = 32'd5; rt_value = 32'd5;
    lo_we = 1'b1; wr_data = 32'h0000AAAA;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    chk("mtlo_ignored_busy", 64'(lo), 64'(32'h00001111));
    chk("still_busy", 64'(busy), 64'(1));
    wait_idle();
    lo_we = 1'b1; wr_data = 32'h0000AAAA;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_idle_lo", 64'(lo), 64'(32'h0000AAAA));
    chk("mtlo_idle_hi", 64'(hi), 64'(32'd2));

    e = model(2'd2, 32'd1000, 32'd9);
    op = 2'd2; rs_value = 32'd1000; rt_value = 32'd9; start = 1'b1;
    lo_we = 1'b1; wr_data = 32'h00005555;
    e.issue = cyc; sb.push_back(e); issued++;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    chk("start_beats_mtlo", 64'(lo), 64'(32'h0000AAAA));

    issue(2'd3, 32'hFFFFFFCE, 32'd3, model(2'd3, 32'hFFFFFFCE, 32'd3));
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midop_reset_busy", 64'(busy), 64'(0));
    chk("midop_reset_hi", 64'(hi), 64'(0));
    chk("midop_reset_lo", 64'(lo), 64'(0));
    chk("midop_reset_done", 64'(done), 64'(0));
    sb.delete();
    issued--;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_reset_busy", 64'(busy), 64'(0));
    issue(2'd2, 32'd100, 32'd7, model(2'd2, 32'd100, 32'd7));

    n = 0;
    while (sb.size() > 0 && n < 200) begin @(negedge clk); n++; end
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    chk("done_pulse_count", 64'(dones), 64'(issued));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
